// File: rtl/decimal_request_arbiter.sv
// decimal_request_arbiter: arbitrates ten decimal requesters onto a BCD valid/ready channel
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : one request bit per decimal digit (bit i = digit i)
//   out_ready : downstream accept for the BCD channel
//   out_valid : out_bcd holds a granted digit
//   out_bcd   : BCD code (0-9) of the granted requester
//   grant     : one-hot grant, zero when no grant is held
//   ack       : one-cycle one-hot pulse on the requester whose transfer is accepted
//   err       : sticky flag, granted requester dropped req before acceptance
//   xfer_cnt  : wrapping count of accepted transfers
module decimal_request_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] req,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_bcd,
   output logic [9:0] grant,
   output logic [9:0] ack,
   output logic       err,
   output logic [7:0] xfer_cnt
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_ptr, r_bcd, w_win;
   logic [9:0] r_grant;
   logic       r_err, w_accept;
   logic [7:0] r_cnt;
   assign w_accept = (r_state == GRANT) && out_ready;
   // Search upward from ptr (or from 0 in fixed priority), wrapping 9 -> 0.
   always_comb begin
      logic       found;
      logic [4:0] j;
      w_win = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < 10; k++) begin
         j = (RR_EN ? {1'b0, r_ptr} : 5'd0) + 5'(k);
         j = (j >= 5'd10) ? j - 5'd10 : j;
         if (!found && req[j[3:0]]) begin
            w_win = j[3:0];
            found = 1'b1;
         end
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == IDLE && req != '0) w_state_nxt = GRANT;
      else if (w_accept) w_state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_bcd   <= '0;
         r_grant <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && req != '0) begin
            r_grant <= 10'(1) << w_win;
            r_bcd   <= w_win;
         end else if (w_accept) begin
            r_grant <= '0;
            r_bcd   <= '0;
            r_cnt   <= r_cnt + 8'd1;
            r_ptr   <= (r_bcd == 4'd9) ? 4'd0 : r_bcd + 4'd1;
         end
         // r_grant is non-zero only in GRANT, so this flags a dropped request there.
         if (|(r_grant & ~req)) r_err <= 1'b1;
      end
   end
   always_comb begin
      out_valid = (r_state == GRANT);
      out_bcd   = r_bcd;
      grant     = r_grant;
      ack       = w_accept ? r_grant : '0;
      err       = r_err;
      xfer_cnt  = r_cnt;
   end
endmodule

// File: tb/tb_decimal_request_arbiter.sv
// tb_decimal_request_arbiter: directed bench with BCD scoreboard for both arbitration policies
module tb_decimal_request_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] req = '0;
   logic       out_ready = 1'b0;
   logic       rr_valid, fp_valid, rr_err, fp_err;
   logic [3:0] rr_bcd, fp_bcd;
   logic [9:0] rr_grant, fp_grant, rr_ack, fp_ack;
   logic [7:0] rr_cnt, fp_cnt;
   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   decimal_request_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
      .out_valid(rr_valid), .out_bcd(rr_bcd), .grant(rr_grant), .ack(rr_ack),
      .err(rr_err), .xfer_cnt(rr_cnt));
   decimal_request_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
      .out_valid(fp_valid), .out_bcd(fp_bcd), .grant(fp_grant), .ack(fp_ack),
      .err(fp_err), .xfer_cnt(fp_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted round-robin transfer must match the next queued digit.
   always @(negedge clk) begin
      if (rst_n && rr_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 32'(rr_bcd), 32'hFFFF);
         else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            chk("sb_bcd", 32'(rr_bcd), 32'(e));
            chk("sb_ack", 32'(rr_ack), 32'(10'(1) << e));
         end
      end
   end

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(rr_valid), 0);
      chk("rst_grant", 32'(rr_grant), 0);
      chk("rst_cnt", 32'(rr_cnt), 0);
      tick();
      rst_n = 1'b1;
      // Single request
      req = 10'h080; out_ready = 1'b1; exp_q.push_back(4'd7);
      tick();
      chk("single_valid", 32'(rr_valid), 1);
      chk("single_bcd", 32'(rr_bcd), 7);
      chk("single_grant", 32'(rr_grant), 32'h080);
      chk("single_ack", 32'(rr_ack), 32'h080);
      req = '0;
      tick();
      chk("single_valid_clr", 32'(rr_valid), 0);
      chk("single_cnt", 32'(rr_cnt), 1);
      // Mid-run reset abandons a pending grant immediately
      req = 10'h004; out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(rr_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(rr_valid), 0);
      chk("midrst_bcd", 32'(rr_bcd), 0);
      chk("midrst_grant", 32'(rr_grant), 0);
      chk("midrst_ack", 32'(rr_ack), 0);
      chk("midrst_err", 32'(rr_err), 0);
      chk("midrst_cnt", 32'(rr_cnt), 0);
      chk("midrst_fp_grant", 32'(fp_grant), 0);
      req = '0;
      tick();
      rst_n = 1'b1;
      // Round-robin vs fixed priority with all requests held
      req = 10'h3FF; out_ready = 1'b1;
      for (int i = 0; i < 11; i++) exp_q.push_back(4'(i % 10));
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("rr_bcd", 32'(rr_bcd), 32'(i % 10));
         chk("fp_bcd", 32'(fp_bcd), 0);
         tick();
         chk("rr_gap", 32'(rr_valid), 0);
      end
      req = '0;
      chk("rr_cnt", 32'(rr_cnt), 11);
      chk("fp_cnt", 32'(fp_cnt), 11);
      // Backpressure
      req = 10'h004; out_ready = 1'b0; exp_q.push_back(4'd2);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(rr_valid), 1);
         chk("bp_bcd", 32'(rr_bcd), 2);
         chk("bp_grant", 32'(rr_grant), 32'h004);
         chk("bp_ack", 32'(rr_ack), 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ack_rel", 32'(rr_ack), 32'h004);
      tick();
      req = '0;
      chk("bp_valid_clr", 32'(rr_valid), 0);
      // Protocol error: granted requester drops req under backpressure
      req = 10'h008; out_ready = 1'b0; exp_q.push_back(4'd3);
      tick();
      chk("err_before", 32'(rr_err), 0);
      req = '0;
      tick();
      chk("err_set", 32'(rr_err), 1);
      chk("err_fp_set", 32'(fp_err), 1);
      chk("err_still_valid", 32'(rr_valid), 1);
      out_ready = 1'b1;
      tick();
      chk("err_done_valid", 32'(rr_valid), 0);
      chk("err_done_cnt", 32'(rr_cnt), 13);
      tick();
      chk("err_sticky", 32'(rr_err), 1);
      // Counter wrap after a fresh reset
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      chk("err_cleared", 32'(rr_err), 0);
      req = 10'h3FF;
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(4'(i % 10));
         tick();
         tick();
         if (i == 254) chk("wrap_255", 32'(rr_cnt), 255);
      end
      req = '0;
      chk("wrap_0", 32'(rr_cnt), 0);
      chk("wrap_fp_0", 32'(fp_cnt), 0);
      tick();
      chk("sb_drain", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
